// File: rtl/spmc_spi_slave_pkg.sv
// Shared definitions for the SPI slave peripheral: register offsets, bit
// positions, the underrun fill byte and the slave FSM state type.
package spmc_spi_slave_pkg;

    // Register offsets (addr_peri[2:0])
    localparam logic [2:0] OFF_DATA   = 3'd0;
    localparam logic [2:0] OFF_STATUS = 3'd1;
    localparam logic [2:0] OFF_CTRL   = 3'd2;
    localparam logic [2:0] OFF_CLEAR  = 3'd3;

    // STATUS bit positions
    localparam int unsigned ST_RX_NE      = 0;
    localparam int unsigned ST_RX_FULL    = 1;
    localparam int unsigned ST_TX_EMPTY   = 2;
    localparam int unsigned ST_TX_FULL    = 3;
    localparam int unsigned ST_RX_OVR     = 4;
    localparam int unsigned ST_TX_UNDR    = 5;
    localparam int unsigned ST_TX_OVF     = 6;
    localparam int unsigned ST_ABORT      = 7;
    localparam int unsigned ST_BUSY       = 8;
    localparam int unsigned ST_RX_CNT_LSB = 9;
    localparam int unsigned ST_TX_CNT_LSB = 13;

    // CTRL bit positions
    localparam int unsigned CTRL_EN = 0;
    localparam int unsigned CTRL_IE = 1;

    // Byte shifted out when the master clocks a byte with nothing queued
    localparam logic [7:0] UNDERRUN_FILL = 8'hFF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT
    } slave_state_t;

endpackage

// File: rtl/spi_slave_fifo.sv
// 8-bit synchronous FIFO with occupancy count. Pushes while full and pops
// while empty are ignored; a simultaneous push and pop both take effect.
module spi_slave_fifo
    import spmc_spi_slave_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_peri,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // Storage array, written at the tail
    always_ff @(posedge clk_peri) begin
        if (push_ok)
            mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally since DEPTH is a power of 2
    always_ff @(posedge clk_peri or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/spmc_spi_slave.sv
// SPI mode-0 slave peripheral with TX/RX byte FIFOs on the CPU bus.
// SPI pins are oversampled on clk_peri; clk_peri must run >= 8x SCLK.
module spmc_spi_slave
    import spmc_spi_slave_pkg::*;
#(
    parameter logic [9:0]  BASE_ADR   = 10'h0,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk_peri,
    input  logic        reset,
    input  logic [17:0] do_peri,
    output logic [17:0] di_peri,
    input  logic [9:0]  addr_peri,
    input  logic        access_peri,
    input  logic        wr_peri,
    input  logic        spi_sclk,
    input  logic        spi_mosi,
    input  logic        spi_cs_n,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    output logic        irq
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    // CPU bus decode
    logic       sel, cpu_wr, cpu_rd;
    logic [2:0] off;
    logic       en, ie;
    logic       rx_ovr, tx_undr, tx_ovf, abort_f;
    logic [3:0] clr;
    logic       unused_bits;

    assign sel         = access_peri & (addr_peri[9:3] == BASE_ADR[9:3]);
    assign off         = addr_peri[2:0];
    assign cpu_wr      = sel & wr_peri;
    assign cpu_rd      = sel & ~wr_peri;
    assign clr         = (cpu_wr && off == OFF_CLEAR) ? do_peri[7:4] : '0;
    assign unused_bits = ^do_peri[17:8];

    // Synchronizers and edge detection
    logic sclk_s1, sclk_s2, sclk_q;
    logic cs_s1, cs_s2, cs_q;
    logic mosi_s1, mosi_s2;
    logic sclk_rise, sclk_fall, cs_fall;

    assign sclk_rise = sclk_s2 & ~sclk_q;
    assign sclk_fall = ~sclk_s2 & sclk_q;
    assign cs_fall   = ~cs_s2 & cs_q;

    // FIFOs
    logic          tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0]    tx_head;
    logic [CW-1:0] tx_count;
    logic          rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]    rx_head, rx_byte;
    logic [CW-1:0] rx_count;

    // Slave engine
    slave_state_t state, state_next;
    logic         do_load, do_rise, do_fall, do_abort;
    logic [7:0]   tx_sr, rx_sr;
    logic [3:0]   bit_cnt;
    logic [17:0]  status;

    assign tx_push = cpu_wr && off == OFF_DATA;
    assign tx_pop  = do_load;
    assign rx_pop  = cpu_rd && off == OFF_DATA;
    assign rx_push = do_rise && bit_cnt == 4'd7;
    assign rx_byte = {rx_sr[6:0], mosi_s2};

    spi_slave_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk_peri (clk_peri),
        .reset    (reset),
        .push     (tx_push),
        .din      (do_peri[7:0]),
        .pop      (tx_pop),
        .dout     (tx_head),
        .count    (tx_count),
        .full     (tx_full),
        .empty    (tx_empty)
    );

    spi_slave_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk_peri (clk_peri),
        .reset    (reset),
        .push     (rx_push),
        .din      (rx_byte),
        .pop      (rx_pop),
        .dout     (rx_head),
        .count    (rx_count),
        .full     (rx_full),
        .empty    (rx_empty)
    );

    // 2-FF synchronizers plus one delayed copy for edge detection
    always_ff @(posedge clk_peri or negedge reset) begin
        if (!reset) begin
            sclk_s1 <= 1'b0;
            sclk_s2 <= 1'b0;
            sclk_q  <= 1'b0;
            cs_s1   <= 1'b1;
            cs_s2   <= 1'b1;
            cs_q    <= 1'b1;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            sclk_s1 <= spi_sclk;
            sclk_s2 <= sclk_s1;
            sclk_q  <= sclk_s2;
            cs_s1   <= spi_cs_n;
            cs_s2   <= cs_s1;
            cs_q    <= cs_s2;
            mosi_s1 <= spi_mosi;
            mosi_s2 <= mosi_s1;
        end
    end

    // FSM state register
    always_ff @(posedge clk_peri or negedge reset) begin
        if (!reset)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    // FSM next state and per-cycle datapath strobes
    always_comb begin
        state_next = state;
        do_load    = 1'b0;
        do_rise    = 1'b0;
        do_fall    = 1'b0;
        do_abort   = 1'b0;
        case (state)
            S_IDLE: begin
                if (en && cs_fall)
                    state_next = S_LOAD;
            end
            S_LOAD: begin
                if (!en) begin
                    state_next = S_IDLE;
                end else begin
                    do_load    = 1'b1;
                    state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (!en) begin
                    state_next = S_IDLE;
                end else if (cs_s2) begin
                    // cs_n level rather than edge, so a release landing during LOAD is not missed
                    state_next = S_IDLE;
                    do_abort   = (bit_cnt != 4'd0) && (bit_cnt != 4'd8);
                end else if (sclk_rise && bit_cnt != 4'd8) begin
                    do_rise = 1'b1;
                end else if (sclk_fall) begin
                    if (bit_cnt == 4'd8)
                        state_next = S_LOAD;
                    else
                        do_fall = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Shift registers and bit counter
    always_ff @(posedge clk_peri or negedge reset) begin
        if (!reset) begin
            tx_sr   <= '1;
            rx_sr   <= '0;
            bit_cnt <= '0;
        end else begin
            if (do_load) begin
                tx_sr   <= tx_empty ? UNDERRUN_FILL : tx_head;
                bit_cnt <= '0;
            end
            if (do_rise) begin
                rx_sr   <= rx_byte;
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (do_fall)
                tx_sr <= {tx_sr[6:0], 1'b1};
        end
    end

    // Control register and sticky flags; a set in the same cycle beats a clear
    always_ff @(posedge clk_peri or negedge reset) begin
        if (!reset) begin
            en      <= 1'b0;
            ie      <= 1'b0;
            rx_ovr  <= 1'b0;
            tx_undr <= 1'b0;
            tx_ovf  <= 1'b0;
            abort_f <= 1'b0;
        end else begin
            if (cpu_wr && off == OFF_CTRL) begin
                en <= do_peri[CTRL_EN];
                ie <= do_peri[CTRL_IE];
            end
            rx_ovr  <= (rx_ovr  & ~clr[0]) | (rx_push & rx_full);
            tx_undr <= (tx_undr & ~clr[1]) | (do_load & tx_empty);
            tx_ovf  <= (tx_ovf  & ~clr[2]) | (tx_push & tx_full);
            abort_f <= (abort_f & ~clr[3]) | do_abort;
        end
    end

    // STATUS word assembly
    always_comb begin
        status                         = '0;
        status[ST_RX_NE]               = ~rx_empty;
        status[ST_RX_FULL]             = rx_full;
        status[ST_TX_EMPTY]            = tx_empty;
        status[ST_TX_FULL]             = tx_full;
        status[ST_RX_OVR]              = rx_ovr;
        status[ST_TX_UNDR]             = tx_undr;
        status[ST_TX_OVF]              = tx_ovf;
        status[ST_ABORT]               = abort_f;
        status[ST_BUSY]                = (state != S_IDLE);
        status[ST_RX_CNT_LSB +: 4]     = 4'(rx_count);
        status[ST_TX_CNT_LSB +: 4]     = 4'(tx_count);
    end

    // Registered read data, zero whenever no read of this block was issued
    always_ff @(posedge clk_peri or negedge reset) begin
        if (!reset) begin
            di_peri <= '0;
        end else if (cpu_rd) begin
            case (off)
                OFF_DATA:   di_peri <= rx_empty ? '0 : {10'b0, rx_head};
                OFF_STATUS: di_peri <= status;
                OFF_CTRL:   di_peri <= {16'b0, ie, en};
                default:    di_peri <= '0;
            endcase
        end else begin
            di_peri <= '0;
        end
    end

    assign spi_miso    = (state != S_IDLE) ? tx_sr[7] : 1'b1;
    assign spi_miso_oe = en & ~cs_s2;
    assign irq         = ie & (~rx_empty | rx_ovr | abort_f);

endmodule

// File: tb/tb_spmc_spi_slave.sv
// Directed bench for spmc_spi_slave: CPU bus tasks plus a bit-banged
// mode-0 SPI master; all expected values are hand-computed constants.
module tb_spmc_spi_slave;

    localparam logic [9:0] BASE = 10'h040;

    logic        clk_peri = 1'b0;
    logic        reset;
    logic [17:0] do_peri;
    logic [17:0] di_peri;
    logic [9:0]  addr_peri;
    logic        access_peri;
    logic        wr_peri;
    logic        spi_sclk;
    logic        spi_mosi;
    logic        spi_cs_n;
    logic        spi_miso;
    logic        spi_miso_oe;
    logic        irq;

    int total = 0;
    int bad   = 0;

    spmc_spi_slave #(.BASE_ADR(BASE), .FIFO_DEPTH(4)) dut (
        .clk_peri    (clk_peri),
        .reset       (reset),
        .do_peri     (do_peri),
        .di_peri     (di_peri),
        .addr_peri   (addr_peri),
        .access_peri (access_peri),
        .wr_peri     (wr_peri),
        .spi_sclk    (spi_sclk),
        .spi_mosi    (spi_mosi),
        .spi_cs_n    (spi_cs_n),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .irq         (irq)
    );

    always #5 clk_peri = ~clk_peri;

    // Time limit so the run always ends
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic cpu_wr(input logic [2:0] off, input logic [17:0] d);
        @(negedge clk_peri);
        access_peri = 1'b1; wr_peri = 1'b1; addr_peri = BASE | {7'b0, off}; do_peri = d;
        @(negedge clk_peri);
        access_peri = 1'b0; wr_peri = 1'b0; do_peri = '0;
    endtask

    task automatic cpu_rd(input logic [9:0] adr, output logic [17:0] d);
        @(negedge clk_peri);
        access_peri = 1'b1; wr_peri = 1'b0; addr_peri = adr;
        @(negedge clk_peri);
        access_peri = 1'b0;
        d = di_peri;
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] off, input logic [17:0] exp);
        logic [17:0] d;
        cpu_rd(BASE | {7'b0, off}, d);
        chk(tag, {14'b0, d}, {14'b0, exp});
    endtask

    task automatic cs_low();
        @(negedge clk_peri);
        spi_cs_n = 1'b0;
        repeat (8) @(negedge clk_peri);
    endtask

    task automatic cs_high();
        spi_cs_n = 1'b1;
        repeat (8) @(negedge clk_peri);
    endtask

    // Clock n bits MSB first; miso is captured as sclk rises
    task automatic spi_bits(input logic [7:0] mo, input int unsigned n, output logic [7:0] mi);
        mi = '0;
        for (int unsigned i = 0; i < n; i++) begin
            spi_mosi = mo[7-i];
            repeat (8) @(negedge clk_peri);
            spi_sclk = 1'b1;
            mi = {mi[6:0], spi_miso};
            repeat (8) @(negedge clk_peri);
            spi_sclk = 1'b0;
        end
        repeat (8) @(negedge clk_peri);
        spi_mosi = 1'b0;
    endtask

    initial begin
        logic [7:0]  mi;
        logic [17:0] d;
        reset = 1'b0; do_peri = '0; addr_peri = '0; access_peri = 1'b0; wr_peri = 1'b0;
        spi_sclk = 1'b0; spi_mosi = 1'b0; spi_cs_n = 1'b1;
        repeat (3) @(negedge clk_peri);
        chk("rst_di", {14'b0, di_peri}, 32'h0);
        chk("rst_miso", {31'b0, spi_miso}, 32'h1);
        chk("rst_oe", {31'b0, spi_miso_oe}, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        reset = 1'b1;
        @(negedge clk_peri);
        rd_chk("rst_status", 3'd1, 18'h00004);
        rd_chk("rst_ctrl", 3'd2, 18'h0);

        // Basic exchange: A5 out, 3C in
        cpu_wr(3'd2, 18'h1);
        cpu_wr(3'd0, 18'hA5);
        cs_low();
        chk("oe_sel", {31'b0, spi_miso_oe}, 32'h1);
        rd_chk("busy_status", 3'd1, 18'h00104);
        spi_bits(8'h3C, 8, mi);
        chk("miso_a5", {24'b0, mi}, 32'hA5);
        cs_high();
        rd_chk("rx1_status", 3'd1, 18'h00225);
        rd_chk("rx1_data", 3'd0, 18'h0003C);
        @(negedge clk_peri);
        chk("di_idle", {14'b0, di_peri}, 32'h0);
        cpu_wr(3'd3, 18'h20);
        rd_chk("clr_undr", 3'd1, 18'h00004);

        // Underrun: two bytes with an empty TX FIFO
        cs_low();
        spi_bits(8'h11, 8, mi);
        chk("undr_b0", {24'b0, mi}, 32'hFF);
        spi_bits(8'h22, 8, mi);
        chk("undr_b1", {24'b0, mi}, 32'hFF);
        cs_high();
        rd_chk("undr_status", 3'd1, 18'h00425);
        cpu_wr(3'd3, 18'h20);
        rd_chk("undr_clr", 3'd1, 18'h00405);
        rd_chk("undr_rd0", 3'd0, 18'h00011);
        rd_chk("undr_rd1", 3'd0, 18'h00022);

        // RX overrun: five bytes into a four-deep FIFO
        cs_low();
        for (int unsigned b = 1; b <= 5; b++)
            spi_bits(8'(b), 8, mi);
        cs_high();
        rd_chk("ovr_status", 3'd1, 18'h00837);
        for (int unsigned b = 1; b <= 4; b++)
            rd_chk("ovr_data", 3'd0, 18'(b));
        rd_chk("ovr_empty_rd", 3'd0, 18'h0);
        rd_chk("ovr_after", 3'd1, 18'h00034);
        cpu_wr(3'd3, 18'h30);

        // Abort after 5 bits, then a clean frame
        cs_low();
        spi_bits(8'hA0, 5, mi);
        cs_high();
        rd_chk("abort_status", 3'd1, 18'h000A4);
        cs_low();
        spi_bits(8'h5A, 8, mi);
        cs_high();
        rd_chk("abort_next", 3'd1, 18'h002A5);
        rd_chk("abort_data", 3'd0, 18'h0005A);
        cpu_wr(3'd3, 18'hF0);
        rd_chk("abort_clr", 3'd1, 18'h00004);

        // TX overflow
        for (int unsigned b = 0; b < 5; b++)
            cpu_wr(3'd0, 18'(8'h10 + b));
        rd_chk("ovf_status", 3'd1, 18'h08048);
        cpu_wr(3'd3, 18'h40);
        rd_chk("ovf_clr", 3'd1, 18'h08008);
        cs_low();
        spi_bits(8'h99, 8, mi);
        chk("txq_b0", {24'b0, mi}, 32'h10);
        cs_high();
        rd_chk("txq_rx", 3'd0, 18'h00099);

        // CPU push in the same cycle as the LOAD pop (third negedge after cs_n falls)
        @(negedge clk_peri);
        spi_cs_n = 1'b0;
        repeat (3) @(negedge clk_peri);
        access_peri = 1'b1; wr_peri = 1'b1; addr_peri = BASE; do_peri = 18'h20;
        @(negedge clk_peri);
        access_peri = 1'b0; wr_peri = 1'b0; do_peri = '0;
        rd_chk("simul_status", 3'd1, 18'h04100);
        spi_bits(8'h55, 8, mi);
        chk("simul_miso", {24'b0, mi}, 32'h12);
        cs_high();
        rd_chk("simul_after", 3'd1, 18'h02201);
        rd_chk("simul_data", 3'd0, 18'h00055);

        // Interrupt
        cpu_wr(3'd3, 18'hF0);
        cpu_wr(3'd2, 18'h3);
        rd_chk("ctrl_rd", 3'd2, 18'h3);
        chk("irq_quiet", {31'b0, irq}, 32'h0);
        cs_low();
        spi_bits(8'h66, 8, mi);
        chk("irq_miso", {24'b0, mi}, 32'h20);
        cs_high();
        chk("irq_set", {31'b0, irq}, 32'h1);
        cpu_rd(BASE, d);
        chk("irq_data", {14'b0, d}, 32'h66);
        chk("irq_clr", {31'b0, irq}, 32'h0);

        // EN dropped mid-frame
        cpu_wr(3'd3, 18'hF0);
        cs_low();
        spi_bits(8'hFF, 3, mi);
        cpu_wr(3'd2, 18'h0);
        rd_chk("endrop_status", 3'd1, 18'h00024);
        chk("endrop_oe", {31'b0, spi_miso_oe}, 32'h0);
        chk("endrop_miso", {31'b0, spi_miso}, 32'h1);
        cs_high();

        // Reserved offsets and foreign base address
        cpu_wr(3'd5, 18'h3FFFF);
        rd_chk("resv_rd", 3'd5, 18'h0);
        cpu_rd(10'h049, d);
        chk("foreign_rd", {14'b0, d}, 32'h0);
        rd_chk("final_status", 3'd1, 18'h00024);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
